// File: rtl/fifo_arb_pkg.sv
// Shared types, default sizes and width helper for the FIFO write-port arbiter family.
package fifo_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_e;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_NUM_REQ    = 4;
  localparam int DEF_MAX_BURST  = 16;

  // Index/counter width that never collapses to zero bits.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Requester handshake plus FIFO write-port bundle; slave is the arbiter, master drives requests.
interface fifo_wr_arbiter_if
  import fifo_arb_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int NUM_REQ    = DEF_NUM_REQ
);
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            req_ready;
  logic                          wr_full;
  logic                          wr_en;
  logic [DATA_WIDTH-1:0]         wr_data;
  logic [NUM_REQ-1:0]            grant;
  logic                          busy;

  modport slave (
    input  req_valid, req_data, wr_full,
    output req_ready, wr_en, wr_data, grant, busy
  );

  modport master (
    output req_valid, req_data, wr_full,
    input  req_ready, wr_en, wr_data, grant, busy
  );
endinterface

// File: rtl/fifo_rr_pick.sv
// Combinational round-robin picker: first set request searching upward (with wrap) from rr_last+1.
module fifo_rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  localparam int IDX_W  = idx_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   rr_last,
  output logic               any_req,
  output logic [IDX_W-1:0]   pick
);

  logic [IDX_W-1:0] cand_s;

  // Walk from the farthest candidate back to the nearest so the nearest set request wins.
  always_comb begin
    any_req = |req;
    pick    = rr_last;
    cand_s  = rr_last;
    for (int i = NUM_REQ; i >= 1; i--) begin
      cand_s = IDX_W'((int'(rr_last) + i) % NUM_REQ);
      pick   = req[cand_s] ? cand_s : pick;
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin, burst-locking arbiter sharing the async FIFO write port among NUM_REQ requesters.
// Optional FIFO_ARB_PRIO_EN: requester 0 is high priority and preempts other bursts at a beat boundary.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int NUM_REQ    = DEF_NUM_REQ,
  parameter int MAX_BURST  = DEF_MAX_BURST
) (
  input logic              wr_clk,
  input logic              wr_rst,
  fifo_wr_arbiter_if.slave bus
);

  localparam int IDX_W = idx_width(NUM_REQ);
  localparam int CNT_W = idx_width(MAX_BURST);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BURST - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_REQ - 1);

  state_e               state_q, state_d;
  logic [IDX_W-1:0]     owner_q, owner_d;
  logic [IDX_W-1:0]     rr_last_q, rr_last_d;
  logic [CNT_W-1:0]     beat_cnt_q, beat_cnt_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic                 busy_q, busy_d;
  logic [IDX_W-1:0]     pick_s;
  logic                 any_req_s;
  logic                 owner_valid_s;
  logic                 fire_s;
  logic                 burst_done_s;
  logic                 prio_s;
  logic [DATA_WIDTH-1:0] owner_data_s;

  fifo_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req     (bus.req_valid),
    .rr_last (rr_last_q),
    .any_req (any_req_s),
    .pick    (pick_s)
  );

`ifdef FIFO_ARB_PRIO_EN
  assign prio_s = bus.req_valid[0];
`else
  assign prio_s = 1'b0;
`endif

  // Zero-latency path from the owner to the FIFO port; only the owner sees ready.
  always_comb begin
    owner_valid_s = bus.req_valid[owner_q];
    owner_data_s  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      owner_data_s = (owner_q == IDX_W'(i)) ? bus.req_data[i*DATA_WIDTH +: DATA_WIDTH] : owner_data_s;
    end
    bus.req_ready = '0;
    if (state_q == BURST && !bus.wr_full) begin
      bus.req_ready[owner_q] = 1'b1;
    end else begin
      bus.req_ready = '0;
    end
    fire_s    = (state_q == BURST) && owner_valid_s && !bus.wr_full;
    bus.wr_en = fire_s;
    if (fire_s) begin
      bus.wr_data = owner_data_s;
    end else begin
      bus.wr_data = '0;
    end
  end

  // Arbitration and burst accounting; a stall on wr_full simply holds everything.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    rr_last_d    = rr_last_q;
    beat_cnt_d   = beat_cnt_q;
    grant_d      = grant_q;
    burst_done_s = (beat_cnt_q == LAST_BEAT) || (prio_s && (owner_q != '0));
    case (state_q)
      IDLE: begin
        if (any_req_s) begin
          state_d    = BURST;
          beat_cnt_d = '0;
          grant_d    = '0;
          if (prio_s) begin
            owner_d    = '0;
            grant_d[0] = 1'b1;
          end else begin
            owner_d         = pick_s;
            rr_last_d       = pick_s;
            grant_d[pick_s] = 1'b1;
          end
        end else begin
          state_d = IDLE;
        end
      end
      BURST: begin
        if (!owner_valid_s || (fire_s && burst_done_s)) begin
          state_d    = IDLE;
          grant_d    = '0;
          beat_cnt_d = '0;
        end else if (fire_s) begin
          beat_cnt_d = beat_cnt_q + CNT_ONE;
        end else begin
          state_d = BURST;
        end
      end
      default: begin
        state_d    = IDLE;
        grant_d    = '0;
        beat_cnt_d = '0;
      end
    endcase
    busy_d = (state_d == BURST);
  end

  // State and registered outputs, synchronous reset.
  always_ff @(posedge wr_clk) begin
    if (wr_rst) begin
      state_q    <= IDLE;
      owner_q    <= '0;
      rr_last_q  <= LAST_IDX;
      beat_cnt_q <= '0;
      grant_q    <= '0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      rr_last_q  <= rr_last_d;
      beat_cnt_q <= beat_cnt_d;
      grant_q    <= grant_d;
      busy_q     <= busy_d;
    end
  end

  assign bus.grant = grant_q;
  assign bus.busy  = busy_q;

endmodule
